// File: rtl/arbiter_n_to_1_request_cache.sv
// rtl/arbiter_n_to_1_request_cache.sv - N-to-1 round-robin request merger
// Per-requestor input buffers feed a shared output buffer toward the cache.
package arbiter_n_to_1_request_cache_pkg;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
  } MemoryPacketRequest;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic full;
    logic empty;
    logic valid;
    logic prog_full;
    logic wr_rst_busy;
    logic rd_rst_busy;
  } FIFOStateSignalsOutput;
endpackage

module arbiter_n_to_1_request_cache
  import arbiter_n_to_1_request_cache_pkg::*;
#(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int INPUT_FIFO_DEPTH     = 4,
  parameter int FIFO_ARBITER_DEPTH   = 16,
  parameter int PROG_THRESH          = FIFO_ARBITER_DEPTH / 2
) (
  input  logic                                  ap_clk,
  input  logic                                  areset,
  input  MemoryPacketRequest [NUM_MEMORY_REQUESTOR-1:0] request_in,
  output logic [NUM_MEMORY_REQUESTOR-1:0]       requestor_ready_out,
  input  FIFOStateSignalsInput                  fifo_request_signals_in,
  output FIFOStateSignalsOutput                 fifo_request_signals_out,
  output MemoryPacketRequest                    request_out,
  output logic                                  fifo_setup_signal
);
  localparam int N  = NUM_MEMORY_REQUESTOR;
  localparam int ID = INPUT_FIFO_DEPTH;
  localparam int OD = FIFO_ARBITER_DEPTH;
  localparam int IW = $clog2(ID);
  localparam int OW = $clog2(OD);
  localparam int GW = $clog2(N);
  localparam logic [IW:0] ICAP      = (IW+1)'(ID);
  localparam logic [IW:0] READY_MAX = (IW+1)'(ID - 3);
  localparam logic [OW:0] OCAP      = (OW+1)'(OD);
  localparam logic [OW:0] OPROG     = (OW+1)'(PROG_THRESH);

  typedef logic [PAYLOAD_W-1:0] payload_t;

  logic [N-1:0]  in_valid_q;
  payload_t      in_payload_q [N];

  payload_t      ibuf_mem [N][ID];
  logic [IW-1:0] ibuf_wptr_q [N];
  logic [IW-1:0] ibuf_rptr_q [N];
  logic [IW:0]   ibuf_cnt_q [N];
  logic [IW:0]   ibuf_cnt_d [N];
  logic [N-1:0]  ibuf_push, ibuf_pop, ibuf_nonempty;

  logic          grant_any;
  logic [GW-1:0] grant_idx, last_grant_q, cand;
  logic [GW:0]   cand_sum;
  logic          grant_valid_q;
  payload_t      grant_payload_q;
  logic [OW+1:0] out_pending;

  payload_t      out_mem [OD];
  logic [OW-1:0] out_wptr_q, out_rptr_q;
  logic [OW:0]   out_cnt_q, out_cnt_d;
  logic          out_push, out_pop, rd_en_q;

  logic          out_valid_q;
  payload_t      out_payload_q;
  logic [N-1:0]  ready_q;
  logic          full_q, empty_q, prog_full_q, rst_busy_q, setup_q;

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      in_valid_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) in_valid_q[i] <= request_in[i].valid;
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < N; i++) in_payload_q[i] <= request_in[i].payload;
  end

  // A write into a full buffer is dropped even if the same edge pops.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ibuf_nonempty[i] = (ibuf_cnt_q[i] != '0);
      ibuf_push[i]     = in_valid_q[i] && (ibuf_cnt_q[i] != ICAP);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ibuf_pop[i]   = grant_any && (grant_idx == GW'(i));
      ibuf_cnt_d[i] = ibuf_cnt_q[i] + (IW+1)'(ibuf_push[i]) - (IW+1)'(ibuf_pop[i]);
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N; i++) begin
        ibuf_wptr_q[i] <= '0;
        ibuf_rptr_q[i] <= '0;
        ibuf_cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ibuf_push[i]) ibuf_wptr_q[i] <= ibuf_wptr_q[i] + 1'b1;
        if (ibuf_pop[i])  ibuf_rptr_q[i] <= ibuf_rptr_q[i] + 1'b1;
        ibuf_cnt_q[i] <= ibuf_cnt_d[i];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < N; i++) begin
      if (ibuf_push[i]) ibuf_mem[i][ibuf_wptr_q[i]] <= in_payload_q[i];
    end
  end

  // The in-flight grant counts against output space so the buffer never overflows.
  assign out_pending = {1'b0, out_cnt_q} + (OW+2)'(grant_valid_q);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    if (out_pending < (OW+2)'(OD)) begin
      for (int k = 1; k <= N; k++) begin
        cand_sum = {1'b0, last_grant_q} + (GW+1)'(k);
        if (cand_sum >= (GW+1)'(N)) cand_sum = cand_sum - (GW+1)'(N);
        cand = cand_sum[GW-1:0];
        if (!grant_any && ibuf_nonempty[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      grant_valid_q <= 1'b0;
      last_grant_q  <= GW'(N - 1);
    end else begin
      grant_valid_q <= grant_any;
      if (grant_any) last_grant_q <= grant_idx;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (grant_any) grant_payload_q <= ibuf_mem[grant_idx][ibuf_rptr_q[grant_idx]];
  end

  assign out_pop   = rd_en_q && (out_cnt_q != '0);
  assign out_push  = grant_valid_q && ((out_cnt_q != OCAP) || out_pop);
  assign out_cnt_d = out_cnt_q + (OW+1)'(out_push) - (OW+1)'(out_pop);

  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      out_wptr_q  <= '0;
      out_rptr_q  <= '0;
      out_cnt_q   <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ready_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      prog_full_q <= 1'b0;
      rst_busy_q  <= 1'b1;
      setup_q     <= 1'b1;
    end else begin
      if (out_push) out_wptr_q <= out_wptr_q + 1'b1;
      if (out_pop)  out_rptr_q <= out_rptr_q + 1'b1;
      out_cnt_q   <= out_cnt_d;
      rd_en_q     <= fifo_request_signals_in.rd_en;
      out_valid_q <= out_pop;
      for (int i = 0; i < N; i++) ready_q[i] <= (ibuf_cnt_q[i] <= READY_MAX);
      full_q      <= (out_cnt_q == OCAP);
      empty_q     <= (out_cnt_q == '0);
      prog_full_q <= (out_cnt_q >= OPROG);
      rst_busy_q  <= 1'b0;
      setup_q     <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (out_push) out_mem[out_wptr_q] <= grant_payload_q;
    if (out_pop)  out_payload_q <= out_mem[out_rptr_q];
  end

  always_comb begin
    request_out.valid                    = out_valid_q;
    request_out.payload                  = out_payload_q;
    fifo_request_signals_out.full        = full_q;
    fifo_request_signals_out.empty       = empty_q;
    fifo_request_signals_out.valid       = out_valid_q;
    fifo_request_signals_out.prog_full   = prog_full_q;
    fifo_request_signals_out.wr_rst_busy = rst_busy_q;
    fifo_request_signals_out.rd_rst_busy = rst_busy_q;
  end

  assign requestor_ready_out = ready_q;
  assign fifo_setup_signal   = setup_q;
endmodule

// File: tb/tb_arbiter_n_to_1_request_cache.sv
// tb/tb_arbiter_n_to_1_request_cache.sv - queue-model bench for arbiter_n_to_1_request_cache
module tb_arbiter_n_to_1_request_cache;
  import arbiter_n_to_1_request_cache_pkg::*;
  localparam int N = 2, ID = 4, OD = 16, PT = 8;

  logic ap_clk = 1'b0;
  logic areset = 1'b1;
  MemoryPacketRequest [N-1:0] req;
  FIFOStateSignalsInput       fin;
  FIFOStateSignalsOutput      fout;
  MemoryPacketRequest         rout;
  logic [N-1:0]               rdy;
  logic                       setup;

  arbiter_n_to_1_request_cache #(
    .NUM_MEMORY_REQUESTOR(N), .INPUT_FIFO_DEPTH(ID),
    .FIFO_ARBITER_DEPTH(OD), .PROG_THRESH(PT)
  ) dut (
    .ap_clk(ap_clk), .areset(areset), .request_in(req),
    .requestor_ready_out(rdy), .fifo_request_signals_in(fin),
    .fifo_request_signals_out(fout), .request_out(rout),
    .fifo_setup_signal(setup)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0, fails = 0, cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain queues per requestor plus one output queue.
  bit          pipe_v [N];
  logic [31:0] pipe_p [N];
  logic [31:0] iq [N][$];
  logic [31:0] oq [$];
  bit          gv_m, rd_m, ov_m;
  logic [31:0] gp_m, op_m;
  int          last_m;
  bit [N-1:0]  rdy_m;
  bit          full_m, empty_m, prog_m, busy_m, setup_m;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      pipe_v[i] = 0;
      iq[i].delete();
    end
    oq.delete();
    gv_m = 0; rd_m = 0; ov_m = 0; last_m = N - 1; rdy_m = '0;
    full_m = 0; empty_m = 1; prog_m = 0; busy_m = 1; setup_m = 1;
  endtask

  task automatic model_step();
    int isz [N];
    int osz, gi;
    bit g;
    for (int i = 0; i < N; i++) isz[i] = iq[i].size();
    osz  = oq.size();
    ov_m = rd_m && (osz > 0);
    if (ov_m) op_m = oq.pop_front();
    if (gv_m) oq.push_back(gp_m);
    g = 0; gi = 0;
    if (osz + int'(gv_m) < OD) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last_m + k) % N;
        if (!g && isz[j] > 0) begin g = 1; gi = j; end
      end
    end
    if (g) begin gp_m = iq[gi].pop_front(); last_m = gi; end
    gv_m = g;
    for (int i = 0; i < N; i++) begin
      if (pipe_v[i] && isz[i] < ID) iq[i].push_back(pipe_p[i]);
      pipe_v[i] = req[i].valid;
      pipe_p[i] = req[i].payload;
      rdy_m[i]  = (isz[i] <= ID - 3);
    end
    full_m = (osz == OD); empty_m = (osz == 0); prog_m = (osz >= PT);
    rd_m = fin.rd_en; busy_m = 0; setup_m = 0;
  endtask

  always @(posedge ap_clk) begin
    cyc++;
    if (areset) model_reset();
    else model_step();
  end

  logic [31:0] log_p [$];
  int          log_c [$];

  always @(negedge ap_clk) begin
    if (areset) begin
      chk("rst_valid", 32'(rout.valid), 0);
      chk("rst_ready", 32'(rdy), 0);
      chk("rst_full", 32'(fout.full), 0);
      chk("rst_empty", 32'(fout.empty), 1);
      chk("rst_prog", 32'(fout.prog_full), 0);
      chk("rst_wrbusy", 32'(fout.wr_rst_busy), 1);
      chk("rst_rdbusy", 32'(fout.rd_rst_busy), 1);
      chk("rst_setup", 32'(setup), 1);
    end else begin
      chk("out_valid", 32'(rout.valid), 32'(ov_m));
      if (ov_m) chk("out_payload", rout.payload, op_m);
      chk("ready", 32'(rdy), 32'(rdy_m));
      chk("full", 32'(fout.full), 32'(full_m));
      chk("empty", 32'(fout.empty), 32'(empty_m));
      chk("flag_valid", 32'(fout.valid), 32'(ov_m));
      chk("prog_full", 32'(fout.prog_full), 32'(prog_m));
      chk("wr_busy", 32'(fout.wr_rst_busy), 32'(busy_m));
      chk("rd_busy", 32'(fout.rd_rst_busy), 32'(busy_m));
      chk("setup", 32'(setup), 32'(setup_m));
      if (rout.valid) begin
        log_p.push_back(rout.payload);
        log_c.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    tick();
    areset = 1'b1;
    for (int i = 0; i < N; i++) req[i].valid = 1'b0;
    ticks(2);
    areset = 1'b0;
    tick();
    log_p.delete();
    log_c.delete();
  endtask

  int n0, sent;

  initial begin
    req = '0;
    fin = '0;
    ticks(3);
    chk("lit_reset_setup", 32'(setup), 1);
    chk("lit_reset_empty", 32'(fout.empty), 1);
    areset = 1'b0;
    tick();
    chk("lit_release_setup", 32'(setup), 0);
    chk("lit_release_ready", 32'(rdy), 32'h3);
    chk("lit_release_busy", 32'(fout.wr_rst_busy), 0);

    // single request, 5-cycle latency
    fin.rd_en = 1'b1;
    ticks(2);
    log_p.delete(); log_c.delete();
    req[0].valid = 1'b1; req[0].payload = 32'h0000_0A5A;
    n0 = cyc;
    tick();
    req[0].valid = 1'b0;
    ticks(12);
    chk("lit_single_count", 32'(log_p.size()), 1);
    if (log_p.size() > 0) begin
      chk("lit_single_latency", 32'(log_c[0] - n0), 5);
      chk("lit_single_payload", log_p[0], 32'h0000_0A5A);
    end

    // contention: strict alternation starting at requestor 0
    do_reset();
    fin.rd_en = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      req[0].valid = 1'b1; req[0].payload = 32'(s);
      req[1].valid = 1'b1; req[1].payload = 32'h1000_0000 | 32'(s);
      tick();
    end
    req[0].valid = 1'b0; req[1].valid = 1'b0;
    ticks(30);
    chk("lit_contention_count", 32'(log_p.size()), 8);
    for (int k = 0; k < 8 && k < log_p.size(); k++)
      chk("lit_contention_order", log_p[k], (32'(k % 2) << 28) | 32'(k / 2));

    // backpressure: requestor 1 streams under ready with rd_en low
    do_reset();
    fin.rd_en = 1'b0;
    sent = 0;
    for (int c = 0; c < 60; c++) begin
      req[1].valid = rdy[1];
      req[1].payload = 32'h1000_0000 | 32'(sent);
      if (rdy[1]) sent++;
      tick();
    end
    req[1].valid = 1'b0;
    ticks(3);
    chk("lit_bp_full", 32'(fout.full), 1);
    chk("lit_bp_prog", 32'(fout.prog_full), 1);
    chk("lit_bp_ready1", 32'(rdy[1]), 0);
    fin.rd_en = 1'b1;
    ticks(50);
    chk("lit_bp_count", 32'(log_p.size()), 32'(sent));
    for (int k = 0; k < log_p.size(); k++)
      chk("lit_bp_order", log_p[k], 32'h1000_0000 | 32'(k));

    // input overflow: requestor 0 forced valid regardless of ready
    do_reset();
    fin.rd_en = 1'b0;
    for (int s = 0; s < 30; s++) begin
      req[0].valid = 1'b1; req[0].payload = 32'(s);
      tick();
    end
    req[0].valid = 1'b0;
    ticks(3);
    chk("lit_ovf_ready0", 32'(rdy[0]), 0);
    fin.rd_en = 1'b1;
    ticks(50);
    chk("lit_ovf_count", 32'(log_p.size()), 20);
    for (int k = 0; k < log_p.size(); k++)
      chk("lit_ovf_order", log_p[k], 32'(k));

    // reset with 10 entries buffered
    do_reset();
    fin.rd_en = 1'b0;
    for (int s = 0; s < 5; s++) begin
      req[0].valid = 1'b1; req[0].payload = 32'(s);
      req[1].valid = 1'b1; req[1].payload = 32'h1000_0000 | 32'(s);
      tick();
    end
    req[0].valid = 1'b0; req[1].valid = 1'b0;
    ticks(10);
    chk("lit_mid_prog", 32'(fout.prog_full), 1);
    areset = 1'b1;
    #1;
    chk("lit_mid_valid", 32'(rout.valid), 0);
    chk("lit_mid_empty", 32'(fout.empty), 1);
    chk("lit_mid_setup", 32'(setup), 1);
    ticks(2);
    areset = 1'b0;
    log_p.delete(); log_c.delete();
    fin.rd_en = 1'b1;
    ticks(25);
    chk("lit_mid_no_stale", 32'(log_p.size()), 0);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i].valid   = rdy[i] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
        req[i].payload = $urandom;
      end
      if ((c / 64) % 3 == 0) fin.rd_en = ($urandom_range(0, 7) == 0);
      else                   fin.rd_en = ($urandom_range(0, 3) != 0);
      tick();
    end
    for (int i = 0; i < N; i++) req[i].valid = 1'b0;
    fin.rd_en = 1'b1;
    ticks(60);
    chk("lit_final_empty", 32'(fout.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
